// File: rtl/pr_bridge_timer.sv
// ---------------------------------------------------------------------------
// pr_bridge_timer
//
// Processor-bus bridge for the CPU core. It decodes word addresses into two
// countdown timers (TC0, TC1), returns read data combinationally, and merges
// the timer interrupts with synchronised external interrupt levels into the
// HWInt vector used by the core's exception unit.
//
// Register window per timer (byte offsets from its base):
//   +0x0 CTRL   {28'b0, IM, Mode[1:0], En}   read/write
//   +0x4 PRESET reload value                 read/write
//   +0x8 COUNT  current count                read-only
//   +0xC and every other address read 0, writes are dropped.
//
// Bus protocol: there is no handshake. A read is combinational from PrAddr
// in the same cycle; a write commits at the rising edge where PrWE is high.
//
// Ports
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous, active-low reset
//   PrAddr   in   30  word address [31:2]
//   PrWE     in   1   write strobe
//   PrWD     in   32  write data
//   PrRD     out  32  combinational read data
//   ext_irq  in   4   asynchronous external interrupt levels
//   HWInt    out  6   [10]=TC0 irq, [11]=TC1 irq, [15:12]=synchronised ext_irq
// ---------------------------------------------------------------------------
module pr_bridge_timer #(
    parameter logic [31:0] TC0_BASE    = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE    = 32'h0000_7F10,
    parameter int          SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:2]  PrAddr,
    input  logic         PrWE,
    input  logic [31:0]  PrWD,
    output logic [31:0]  PrRD,
    input  logic [3:0]   ext_irq,
    output logic [15:10] HWInt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } tstate_e;

    logic [1:0][29:0] base_w;
    assign base_w[0] = TC0_BASE[31:2];
    assign base_w[1] = TC1_BASE[31:2];

    // Per-timer state.
    logic [1:0][3:0]  ctrl_q,   ctrl_d;
    logic [1:0][31:0] preset_q, preset_d;
    logic [1:0][31:0] count_q,  count_d;
    tstate_e [1:0]    state_q,  state_d;
    logic [1:0]       flag_q,   flag_d;

    logic [3:0] sync_q [SYNC_STAGES];

    // Address decode.
    logic [1:0] hit_ctrl, hit_preset, hit_count;

    always_comb begin
        hit_ctrl   = '0;
        hit_preset = '0;
        hit_count  = '0;
        for (int i = 0; i < 2; i++) begin
            hit_ctrl[i]   = (PrAddr == base_w[i]);
            hit_preset[i] = (PrAddr == base_w[i] + 30'd1);
            hit_count[i]  = (PrAddr == base_w[i] + 30'd2);
        end
    end

    // Read mux.
    always_comb begin
        PrRD = '0;
        for (int i = 0; i < 2; i++) begin
            if (hit_ctrl[i])   PrRD = {28'b0, ctrl_q[i]};
            if (hit_preset[i]) PrRD = preset_q[i];
            if (hit_count[i])  PrRD = count_q[i];
        end
    end

    // Timer next-state and register update logic.
    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        state_d  = state_q;
        flag_d   = flag_q;
        for (int i = 0; i < 2; i++) begin
            unique case (state_q[i])
                S_IDLE: begin
                    if (ctrl_q[i][0]) state_d[i] = S_LOAD;
                end
                S_LOAD: begin
                    count_d[i] = preset_q[i];
                    state_d[i] = S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_q[i][0]) begin
                        state_d[i] = S_IDLE;
                    end else if (count_q[i] > 32'd1) begin
                        count_d[i] = count_q[i] - 32'd1;
                    end else begin
                        // Reaching 1 lands on 0 and expires in the same step;
                        // a count already at 0 expires without wrapping.
                        count_d[i] = '0;
                        state_d[i] = S_INT;
                    end
                end
                S_INT: begin
                    flag_d[i] = 1'b1;
                    if (ctrl_q[i][2:1] == 2'b01) begin
                        state_d[i] = S_LOAD;
                    end else begin
                        ctrl_d[i][0] = 1'b0;
                        state_d[i]   = S_IDLE;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase

            // Auto-reload flags are a single-cycle pulse; one-shot flags stick.
            if (state_q[i] != S_INT && ctrl_q[i][2:1] == 2'b01) flag_d[i] = 1'b0;

            if (PrWE && hit_preset[i]) preset_d[i] = PrWD;

            // A CPU CTRL write overrides the FSM's En clear and any flag set.
            if (PrWE && hit_ctrl[i]) begin
                ctrl_d[i] = PrWD[3:0];
                flag_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            state_q  <= {S_IDLE, S_IDLE};
            flag_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            state_q  <= state_d;
            flag_q   <= flag_d;
        end
    end

    // External interrupt synchroniser: level passthrough, no latching.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= ext_irq;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign HWInt = {sync_q[SYNC_STAGES-1],
                    flag_q[1] & ctrl_q[1][3],
                    flag_q[0] & ctrl_q[0][3]};

endmodule

// File: tb/tb_pr_bridge_timer.sv
// ---------------------------------------------------------------------------
// tb_pr_bridge_timer
//
// Driver issues bus reads/writes and external interrupt levels once per
// cycle and pushes the expected PrRD / HWInt into queues. The reference
// model describes each timer by its start edge, preset and mode, and derives
// count, En and flag from the documented latencies with plain arithmetic.
// A monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pr_bridge_timer;

    localparam int BIG = 32'h3FFF_FFFF;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:2]  PrAddr;
    logic         PrWE;
    logic [31:0]  PrWD;
    logic [31:0]  PrRD;
    logic [3:0]   ext_irq;
    logic [15:10] HWInt;

    pr_bridge_timer dut (
        .clk     (clk),
        .reset   (reset),
        .PrAddr  (PrAddr),
        .PrWE    (PrWE),
        .PrWD    (PrWD),
        .PrRD    (PrRD),
        .ext_irq (ext_irq),
        .HWInt   (HWInt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    logic        chk_rd = 1'b0;
    logic        chk_hw = 1'b0;
    logic        final_chk = 1'b0;
    logic [31:0] rd_exp_q [$];
    string       rd_tag_q [$];
    logic [5:0]  hw_exp_q [$];

    // ---------------- reference model state ----------------
    logic [3:0]  ext_set [int];   // value sampled at a given edge
    int          s_e [2];         // edge at which CTRL (En=1) was committed
    int          s_n [2];         // preset in use
    logic        s_auto [2];
    logic [1:0]  s_mode [2];
    logic        s_im [2];
    logic [3:0]  s_ctrl_pre [2];  // CTRL contents before s_e
    logic [31:0] s_p [2];         // PRESET register contents

    function automatic int m_of(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic logic [31:0] count_at(input int i, input int c);
        int d, m, r;
        d = c - (s_e[i] + 2);
        if (d < 0) return 32'd0;
        m = m_of(s_n[i]);
        r = s_auto[i] ? (d % (m + 2)) : d;
        if (r > m) return 32'd0;
        return (s_n[i] > r) ? 32'(s_n[i] - r) : 32'd0;
    endfunction

    function automatic logic flag_at(input int i, input int c);
        int f, m;
        m = m_of(s_n[i]);
        f = c - (s_e[i] + m + 3);
        if (f < 0) return 1'b0;
        if (!s_auto[i]) return 1'b1;
        return (f % (m + 2)) == 0;
    endfunction

    function automatic logic [3:0] ctrl_at(input int i, input int c);
        logic en;
        if (c < s_e[i]) return s_ctrl_pre[i];
        en = s_auto[i] ? 1'b1 : (c < s_e[i] + m_of(s_n[i]) + 3);
        return {s_im[i], s_mode[i], en};
    endfunction

    function automatic logic [29:0] addr_of(input int i, input int r);
        return 30'h1FC0 + 30'(4 * i + r);
    endfunction

    function automatic logic [31:0] rd_model(input logic [29:0] a, input int c);
        for (int i = 0; i < 2; i++) begin
            if (a == addr_of(i, 0)) return {28'b0, ctrl_at(i, c)};
            if (a == addr_of(i, 1)) return s_p[i];
            if (a == addr_of(i, 2)) return count_at(i, c);
        end
        return 32'd0;
    endfunction

    function automatic logic [5:0] hw_model(input int c);
        logic [3:0] ev;
        ev = ext_set.exists(c - 1) ? ext_set[c - 1] : 4'h0;
        return {ev, flag_at(1, c) & s_im[1], flag_at(0, c) & s_im[0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        edge_n++;
        #1;
        chk_rd = 1'b0;
        chk_hw = 1'b0;
        PrWE   = 1'b0;
        PrWD   = '0;
    endtask

    task automatic check_rd(input logic [29:0] a, input string tag);
        PrAddr = a;
        rd_exp_q.push_back(rd_model(a, edge_n));
        rd_tag_q.push_back(tag);
        chk_rd = 1'b1;
    endtask

    task automatic check_rd_const(input logic [29:0] a, input logic [31:0] v, input string tag);
        PrAddr = a;
        rd_exp_q.push_back(v);
        rd_tag_q.push_back(tag);
        chk_rd = 1'b1;
    endtask

    task automatic check_hw();
        hw_exp_q.push_back(hw_model(edge_n));
        chk_hw = 1'b1;
    endtask

    task automatic check_hw_const(input logic [5:0] v);
        hw_exp_q.push_back(v);
        chk_hw = 1'b1;
    endtask

    task automatic write_reg(input logic [29:0] a, input logic [31:0] d, input string tag);
        check_rd(a, tag);
        PrWE = 1'b1;
        PrWD = d;
    endtask

    task automatic drive_ext();
        logic [3:0] v;
        v = 4'($urandom_range(0, 15));
        ext_irq = v;
        ext_set[edge_n + 1] = v;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            s_e[i] = BIG; s_n[i] = 0; s_auto[i] = 1'b0; s_mode[i] = 2'b00;
            s_im[i] = 1'b0; s_ctrl_pre[i] = 4'h0; s_p[i] = 32'd0;
        end
        ext_set.delete();
    endtask

    task automatic model_start(input int i, input logic [3:0] c);
        s_e[i]    = edge_n + 1;
        s_im[i]   = c[3];
        s_mode[i] = c[2:1];
        s_auto[i] = (c[2:1] == 2'b01);
    endtask

    // Reset pulse, usually landing mid-count; state must clear at once.
    task automatic do_reset();
        next_cycle(); reset = 1'b0; ext_irq = 4'hF;
        check_rd_const(addr_of(0, 2), 32'd0, "rst_count0"); check_hw_const(6'd0);
        next_cycle();
        check_rd_const(addr_of(0, 0), 32'd0, "rst_ctrl0");  check_hw_const(6'd0);
        next_cycle();
        check_rd_const(addr_of(0, 1), 32'd0, "rst_preset0"); check_hw_const(6'd0);
        next_cycle(); reset = 1'b1;
        model_clear();
        drive_ext(); check_hw(); check_rd(addr_of(1, 2), "post_rst_count1");
    endtask

    // Start a single timer and watch it; optionally clear CTRL after expiry.
    task automatic directed(input int i, input int n, input logic [3:0] c, input int len,
                            input logic do_clr, input logic [3:0] clr);
        do_reset();
        next_cycle(); drive_ext(); check_hw();
        write_reg(addr_of(i, 1), 32'(n), "dir_wr_preset"); s_p[i] = 32'(n); s_n[i] = n;
        next_cycle(); drive_ext(); check_hw();
        write_reg(addr_of(i, 0), {28'b0, c}, "dir_wr_ctrl"); model_start(i, c);
        for (int k = 0; k < len; k++) begin
            next_cycle(); drive_ext(); check_hw();
            if (k % 4 == 3) check_rd(addr_of(i, 0), "dir_ctrl");
            else            check_rd(addr_of(i, 2), "dir_count");
        end
        if (do_clr) begin
            next_cycle(); drive_ext(); check_hw();
            write_reg(addr_of(i, 0), {28'b0, clr}, "dir_clr_ctrl");
            s_ctrl_pre[i] = clr; s_e[i] = BIG;
            for (int k = 0; k < 4; k++) begin
                next_cycle(); drive_ext(); check_hw();
                check_rd(addr_of(i, k % 2 == 0 ? 0 : 2), "dir_after_clr");
            end
        end
    endtask

    task automatic random_scenario();
        logic [3:0] c0, c1;
        int n0, n1, len, sel;
        logic [29:0] a;
        do_reset();
        n0 = $urandom_range(0, 6);
        n1 = $urandom_range(0, 6);
        c0 = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
        c1 = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
        next_cycle(); drive_ext(); check_hw();
        write_reg(addr_of(0, 1), 32'(n0), "wr_preset0"); s_p[0] = 32'(n0); s_n[0] = n0;
        next_cycle(); drive_ext(); check_hw();
        write_reg(addr_of(1, 1), 32'(n1), "wr_preset1"); s_p[1] = 32'(n1); s_n[1] = n1;
        next_cycle(); drive_ext(); check_hw();
        write_reg(addr_of(0, 0), {28'b0, c0}, "wr_ctrl0"); model_start(0, c0);
        next_cycle(); drive_ext(); check_hw();
        write_reg(addr_of(1, 0), {28'b0, c1}, "wr_ctrl1"); model_start(1, c1);
        len = $urandom_range(12, 30);
        for (int k = 0; k < len; k++) begin
            next_cycle(); drive_ext(); check_hw();
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                check_rd(addr_of(sel % 2, sel / 2), "rd_reg");
            end else if (sel == 6) begin
                check_rd(30'h1FC3, "rd_hole0");
            end else if (sel == 7) begin
                check_rd(30'h1FC7, "rd_hole1");
            end else if (sel == 8) begin
                a = 30'($urandom) | (30'h1 << 20);
                check_rd(a, "rd_far");
            end else begin
                // Writes to COUNT and to the +0xC hole must be dropped.
                case ($urandom_range(0, 2))
                    0:       a = addr_of(0, 2);
                    1:       a = addr_of(1, 2);
                    default: a = addr_of($urandom_range(0, 1), 3);
                endcase
                write_reg(a, 32'h0000_DEAD, "wr_dropped");
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic [31:0] mon_rd_exp;
    string       mon_tag;
    logic [5:0]  mon_hw_exp;

    always @(negedge clk) begin
        if (chk_rd) begin
            checks++;
            if (rd_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_queue: no expected value, PrRD=%h", PrRD);
            end else begin
                mon_rd_exp = rd_exp_q.pop_front();
                mon_tag    = rd_tag_q.pop_front();
                if (PrRD !== mon_rd_exp) begin
                    errors++;
                    $display("FAIL %s: PrRD=%h expected %h addr=%h edge=%0d",
                             mon_tag, PrRD, mon_rd_exp, {PrAddr, 2'b00}, edge_n);
                end
            end
        end
        if (chk_hw) begin
            checks++;
            if (hw_exp_q.size() == 0) begin
                errors++;
                $display("FAIL hw_queue: no expected value, HWInt=%b", HWInt);
            end else begin
                mon_hw_exp = hw_exp_q.pop_front();
                if (HWInt !== mon_hw_exp) begin
                    errors++;
                    $display("FAIL hwint: HWInt=%b expected %b edge=%0d", HWInt, mon_hw_exp, edge_n);
                end
            end
        end
        if (final_chk) begin
            checks++;
            if (rd_exp_q.size() != 0 || hw_exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d rd and %0d hw expectations left, required 0",
                         rd_exp_q.size(), hw_exp_q.size());
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset   = 1'b0;
        PrAddr  = '0;
        PrWE    = 1'b0;
        PrWD    = '0;
        ext_irq = 4'hF;
        model_clear();

        // One-shot, IM=1: counts 5..0, sticky irq, En self-clears, CTRL write clears irq.
        directed(0, 5, 4'b1001, 12, 1'b1, 4'b1000);
        // Masked one-shot with PRESET=0; setting IM through a CTRL write must not raise irq.
        directed(0, 0, 4'b0001, 8, 1'b1, 4'b1000);
        // Auto-reload on TC1: one-cycle pulse every 5 cycles.
        directed(1, 3, 4'b1011, 16, 1'b0, 4'b0000);

        for (int s = 0; s < 14; s++) random_scenario();

        do_reset();
        next_cycle();
        final_chk = 1'b1;
        @(negedge clk);
        #1;
        final_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
